// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock-measurement blocks: FSM encodings,
// compile-time helpers and the frequency constants used by the divider chain.
package clk_meas_pkg;

    localparam int unsigned M = 1_000_000;
    localparam int unsigned K = 1_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } meas_state_e;

    // Bits needed to hold values 0..v-1; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector. Reusable for any
// slow asynchronous input (buttons, sensors, clocks under measurement).
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous clock over a gate window of
// REF_HZ/GATE_HZ reference cycles and reports the count once per gate.
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned REF_HZ  = 50_000_000,
    parameter int unsigned GATE_HZ = 1,
    parameter int unsigned CNT_W   = 27
) (
    input  logic             fpga_clk,
    input  logic             rst,
    input  logic             meas_clk,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned GATE_CYCLES = REF_HZ / GATE_HZ;
    localparam int unsigned GW          = (clog2(GATE_CYCLES) < 1) ? 1 : clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    meas_state_e      state_q,    state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q,      ovf_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic             rise;

    // Runs in every state so edges seen before the gate opens never leak in.
    sync_edge_det u_sync (
        .clk_i  (fpga_clk),
        .rst_i  (rst),
        .d_i    (meas_clk),
        .rise_o (rise)
    );

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start || cont) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = GATE;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                if (rise) begin
                    if (&edge_cnt_q) ovf_d = 1'b1;
                    else             edge_cnt_d = edge_cnt_q + 1'b1;
                end
                // Result is latched on entry to DONE so it is stable while valid is high.
                if (gate_cnt_q == GATE_LAST) begin
                    count_d    = edge_cnt_d;
                    overflow_d = ovf_d;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (cont) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = GATE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_out = count_q;
    assign overflow  = overflow_q;
    assign valid     = (state_q == DONE);
    assign busy      = (state_q == GATE) || (state_q == DONE);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench: expected results queued at stimulus time, popped on valid.
module tb_clk_freq_meter;

    typedef struct {
        int vcyc;
        int cnt;
        int tol;
        bit ovf;
    } exp_t;

    logic       fpga_clk = 1'b0;
    logic       rst;
    logic       meas_clk;
    logic       start;
    logic       cont;
    logic       start4;
    logic       cont4;
    logic [7:0] count_out;
    logic       valid, busy, overflow;
    logic [3:0] count4;
    logic       valid4, busy4, ovf4;

    int   cyc = 0;
    int   mper = 0;
    logic mforce = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    exp_t q0[$];
    exp_t q4[$];
    exp_t e0, e4;

    clk_freq_meter #(.REF_HZ(1000), .GATE_HZ(10), .CNT_W(8)) dut (
        .fpga_clk  (fpga_clk),
        .rst       (rst),
        .meas_clk  (meas_clk),
        .start     (start),
        .cont      (cont),
        .count_out (count_out),
        .valid     (valid),
        .busy      (busy),
        .overflow  (overflow)
    );

    clk_freq_meter #(.REF_HZ(1000), .GATE_HZ(10), .CNT_W(4)) dut4 (
        .fpga_clk  (fpga_clk),
        .rst       (rst),
        .meas_clk  (meas_clk),
        .start     (start4),
        .cont      (cont4),
        .count_out (count4),
        .valid     (valid4),
        .busy      (busy4),
        .overflow  (ovf4)
    );

    always #5 fpga_clk = ~fpga_clk;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        checks++;
        if (obs > exp + tol || obs + tol < exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge fpga_clk);
    endtask

    task automatic push0(input int vc, input int cnt, input int tol, input bit ovf);
        exp_t e;
        e.vcyc = vc; e.cnt = cnt; e.tol = tol; e.ovf = ovf;
        q0.push_back(e);
    endtask

    task automatic push4(input int vc, input int cnt, input int tol, input bit ovf);
        exp_t e;
        e.vcyc = vc; e.cnt = cnt; e.tol = tol; e.ovf = ovf;
        q4.push_back(e);
    endtask

    // Measured clock: fixed period in fpga_clk cycles, or a forced level when mper==0.
    initial begin
        meas_clk = 1'b0;
        forever begin
            if (mper == 0) begin
                meas_clk = mforce;
                @(negedge fpga_clk);
            end else begin
                meas_clk = 1'b1;
                repeat (mper / 2) @(negedge fpga_clk);
                meas_clk = 1'b0;
                repeat (mper - mper / 2) @(negedge fpga_clk);
            end
        end
    end

    always @(negedge fpga_clk) begin
        if (valid) begin
            if (q0.size() == 0) chk("dut_spurious_valid", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("valid_cycle", cyc, e0.vcyc);
                chk("count_out", count_out, e0.cnt, e0.tol);
                chk("overflow", overflow, e0.ovf);
            end
        end
        if (valid4) begin
            if (q4.size() == 0) chk("dut4_spurious_valid", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("valid4_cycle", cyc, e4.vcyc);
                chk("count4", count4, e4.cnt, e4.tol);
                chk("overflow4", ovf4, e4.ovf);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; start4 = 1'b0; cont4 = 1'b0;
        tick(2);
        chk("rst_count", count_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick(3);

        // Period 10: ten edges per gate, valid exactly 101 cycles after start.
        mper = 10; tick(30);
        t0 = cyc; push0(t0 + 101, 10, 1, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy_c1", busy, 1);
        wait_until(t0 + 101);
        chk("t1_busy_c101", busy, 1);
        tick();
        chk("t1_busy_c102", busy, 0);

        // Static input reads zero; a single rise mid-gate reads one.
        mper = 0; mforce = 1'b0; tick(30);
        t0 = cyc; push0(t0 + 101, 0, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 104);
        t0 = cyc; push0(t0 + 101, 1, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 50);
        mforce = 1'b1;
        wait_until(t0 + 104);

        // Re-pulsed start mid-gate and on the final gate cycle: one gate only.
        mper = 10; tick(30);
        t0 = cyc; push0(t0 + 101, 10, 1, 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 30);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 100);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t6_no_regate", busy, 0);
        tick(150);

        // Continuous mode, cont dropped during the third gate.
        mper = 5; tick(30);
        t0 = cyc;
        push0(t0 + 101, 20, 1, 0);
        push0(t0 + 202, 20, 1, 0);
        push0(t0 + 303, 20, 1, 0);
        cont = 1'b1;
        wait_until(t0 + 250);
        cont = 1'b0;
        wait_until(t0 + 305);
        chk("t4_idle_busy", busy, 0);
        tick(120);

        // Asynchronous reset mid-gate clears outputs at once and emits no valid.
        mper = 10; tick(30);
        t0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 60);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_count", count_out, 0);
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ovf", overflow, 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("t5_post_busy", busy, 0);
        t0 = cyc; push0(t0 + 101, 10, 1, 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_until(t0 + 104);

        // 4-bit counter saturates at period 4, then recovers at period 20.
        mper = 4; tick(30);
        t0 = cyc; push4(t0 + 101, 15, 0, 1);
        start4 = 1'b1; tick(); start4 = 1'b0;
        wait_until(t0 + 104);
        mper = 20; tick(45);
        t0 = cyc; push4(t0 + 101, 5, 1, 0);
        start4 = 1'b1; tick(); start4 = 1'b0;
        wait_until(t0 + 104);
        tick(10);

        chk("sb0_drain", q0.size(), 0);
        chk("sb4_drain", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
